encoder_8to3: RTL and testbench

Registered 8-to-3 request encoder with a valid/ack handshake; the transmit-side counterpart of the 3-to-8 decoder. It latches request lines d0..d7 into a pending register, selects one pending line, and presents its 3-bit code on A/B/C with A as LSB. A consumer, typically the decoder stage, holds the code until it acknowledges. The encoder then clears the serviced request and moves on to the next one.

---
 rtl/encoder_8to3.sv | 134 +++++++++++++
 tb/tb_encoder_8to3.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 request encoder with valid/ack handshake and optional ack timeout.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest pending index wins.
module encoder_8to3 #(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic ack,
    output logic A,
    output logic B,
    output logic C,
    output logic valid,
    output logic multi,
    output logic to_err
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [N-1:0]    pend;
    logic [N-1:0]    pend_nxt;
    logic [N-1:0]    d_vec;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   sel_c;
    logic [CW-1:0]   cnt;
    logic            multi_c;
    logic            timeout_c;

    assign d_vec   = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign {C, B, A} = grant;
    assign multi_c = ($countones(pend) > 1);

    // Counter sits at ACK_TIMEOUT-1 during the last permitted HOLD cycle.
    assign timeout_c = (ACK_TIMEOUT != 0) && (cnt == CW'(ACK_TIMEOUT - 1));

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0] ptr;

    // Walk from ptr+8 down to ptr+1 so the nearest index above ptr is assigned last.
    always_comb begin
        logic [IW-1:0] idx;
        sel_c = '0;
        idx   = '0;
        for (int i = 8; i > 0; i--) begin
            idx = ptr + IW'(i);
            if (pend[idx]) begin
                sel_c = idx;
            end
        end
    end
`else
    // Fixed priority: the highest set index is the last one assigned.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) begin
                sel_c = IW'(i);
            end
        end
    end
`endif

    // A same-cycle capture overrides the clear of the serviced bit.
    always_comb begin
        pend_nxt = pend;
        if (state == HOLD && ack) begin
            pend_nxt[grant] = 1'b0;
        end
        if (en) begin
            pend_nxt = pend_nxt | d_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            grant  <= '0;
            valid  <= 1'b0;
            multi  <= 1'b0;
            to_err <= 1'b0;
            cnt    <= '0;
`ifdef ROUND_ROBIN_EN
            ptr    <= IW'(7);
`endif
        end else begin
            pend <= pend_nxt;
            case (state)
                IDLE: begin
                    if (pend != '0) begin
                        grant <= sel_c;
                        multi <= multi_c;
                        valid <= 1'b1;
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
`ifdef ROUND_ROBIN_EN
                        ptr   <= grant;
`endif
                    end else if (timeout_c) begin
                        valid  <= 1'b0;
                        to_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3 (ACK_TIMEOUT=4): directed table, wrap sequence, random vs model.
module tb_encoder_8to3;

    localparam int unsigned TO = 4;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       ack;
    logic       A, B, C, valid, multi, to_err;

    int n_cmp = 0;
    int n_err = 0;

    encoder_8to3 #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .ack(ack), .A(A), .B(B), .C(C),
        .valid(valid), .multi(multi), .to_err(to_err)
    );

    always #5 clk = ~clk;

    // Behavioural reference: pending set, busy flag, cycles waited, last serviced index.
    logic [7:0] m_pend;
    logic       m_busy;
    logic [2:0] m_code;
    logic       m_multi;
    logic       m_err;
    int         m_wait;
    int         m_last;

    function automatic logic [2:0] pick(input logic [7:0] p, input int last);
        if (RR) begin
            for (int off = 1; off <= 8; off++) begin
                int j;
                j = (last + off) % 8;
                if (p[j]) return 3'(j);
            end
        end else begin
            for (int j = 7; j >= 0; j--) begin
                if (p[j]) return 3'(j);
            end
        end
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = '0; m_busy = 1'b0; m_code = '0; m_multi = 1'b0;
            m_err = 1'b0; m_wait = 0; m_last = 7;
        end else begin
            logic [7:0] old;
            old = m_pend;
            if (m_busy) begin
                if (ack) begin
                    m_pend[m_code] = 1'b0;
                    m_busy = 1'b0;
                    m_last = int'(m_code);
                end else if (m_wait + 1 == int'(TO)) begin
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (old != 0) begin
                m_code  = pick(old, m_last);
                m_multi = ($countones(old) > 1);
                m_busy  = 1'b1;
                m_wait  = 0;
            end
            if (en) m_pend = m_pend | d;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] dv;
        logic       a;
        logic       v;
        logic [2:0] code;
        logic       m;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [7:0] dv, input logic a,
                       input logic v, input logic [2:0] code, input logic m, input logic err);
        vec_t t;
        t.r = r; t.e = e; t.dv = dv; t.a = a; t.v = v; t.code = code; t.m = m; t.err = err;
        tbl.push_back(t);
    endtask

    // Inputs change at the negedge; outputs are sampled one negedge later.
    task automatic step(input logic r, input logic e, input logic [7:0] dv, input logic a);
        rst = r; en = e; d = dv; ack = a;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] first, second;
        first  = RR ? 3'd1 : 3'd6;
        second = RR ? 3'd6 : 3'd1;
        rst = 1'b1; en = 1'b0; d = '0; ack = 1'b0;

        // r, en, d, ack | valid, code, multi, to_err
        add(1, 0, 8'h00, 0,  0, 3'd0, 0, 0);
        add(0, 1, 8'h20, 1,  0, 3'd0, 0, 0);
        add(0, 1, 8'h00, 1,  1, 3'd5, 0, 0);
        add(0, 1, 8'h00, 1,  0, 3'd5, 0, 0);
        add(0, 1, 8'h00, 1,  0, 3'd5, 0, 0);
        add(1, 1, 8'h00, 1,  0, 3'd0, 0, 0);
        add(0, 1, 8'h42, 1,  0, 3'd0, 0, 0);
        add(0, 1, 8'h00, 1,  1, first, 1, 0);
        add(0, 1, 8'h00, 1,  0, first, 1, 0);
        add(0, 1, 8'h00, 1,  1, second, 0, 0);
        add(0, 1, 8'h00, 1,  0, second, 0, 0);
        add(0, 0, 8'h08, 1,  0, second, 0, 0);
        add(0, 1, 8'h00, 1,  0, second, 0, 0);
        add(0, 1, 8'h08, 1,  0, second, 0, 0);
        add(0, 1, 8'h00, 1,  1, 3'd3, 0, 0);
        add(0, 1, 8'h00, 1,  0, 3'd3, 0, 0);
        add(0, 1, 8'h04, 0,  0, 3'd3, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 8'h00, 0,  1, 3'd2, 0, 0);
        add(0, 1, 8'h00, 0,  0, 3'd2, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 1, 8'h00, 0,  1, 3'd2, 0, 1);
        add(0, 1, 8'h00, 1,  0, 3'd2, 0, 1);
        add(0, 1, 8'h00, 0,  0, 3'd2, 0, 1);
        add(1, 1, 8'h00, 0,  0, 3'd0, 0, 0);
        add(0, 1, 8'h04, 0,  0, 3'd0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 8'h00, 0,  1, 3'd2, 0, 0);
        add(0, 1, 8'h00, 0,  1, 3'd2, 0, 0);
        add(0, 1, 8'h00, 1,  0, 3'd2, 0, 0);
        add(0, 1, 8'h00, 0,  0, 3'd2, 0, 0);
        add(0, 1, 8'h10, 0,  0, 3'd2, 0, 0);
        add(0, 1, 8'h00, 0,  1, 3'd4, 0, 0);
        add(1, 1, 8'h00, 0,  0, 3'd0, 0, 0);
        add(0, 1, 8'h00, 0,  0, 3'd0, 0, 0);
        add(0, 1, 8'h00, 0,  0, 3'd0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].dv, tbl[i].a);
            check($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].v));
            check($sformatf("tbl%0d_code", i), int'({C, B, A}), int'(tbl[i].code));
            check($sformatf("tbl%0d_multi", i), int'(multi), int'(tbl[i].m));
            check($sformatf("tbl%0d_to_err", i), int'(to_err), int'(tbl[i].err));
        end

        // All lines held high with ack tied: a grant every other edge, nine grants.
        step(1, 0, 8'h00, 1);
        step(0, 1, 8'hFF, 1);
        check("wrap_idle", int'(valid), 0);
        for (int j = 0; j < 9; j++) begin
            step(0, 1, 8'hFF, 1);
            check($sformatf("wrap%0d_valid", j), int'(valid), 1);
            check($sformatf("wrap%0d_code", j), int'({C, B, A}), RR ? (j % 8) : 7);
            check($sformatf("wrap%0d_multi", j), int'(multi), 1);
            step(0, 1, 8'hFF, 1);
            check($sformatf("wrap%0d_gap", j), int'(valid), 0);
        end

        // Random traffic compared against the reference model every cycle.
        step(1, 0, 8'h00, 0);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 7) != 0,
                 8'($urandom & $urandom & $urandom),
                 $urandom_range(0, 2) == 0);
            check("rnd_valid", int'(valid), int'(m_busy));
            check("rnd_code", int'({C, B, A}), int'(m_code));
            check("rnd_multi", int'(multi), int'(m_multi));
            check("rnd_to_err", int'(to_err), int'(m_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
